// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared timebase constants for the elevator controller
package elevator_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50000000;

  localparam logic MODE_TRAVEL = 1'b0;
  localparam logic MODE_DOOR   = 1'b1;

  // One floor per second of travel, two seconds of door dwell at 50 MHz
  localparam int unsigned TRAVEL_CYCLES_DEF = 50000000;
  localparam int unsigned DOOR_CYCLES_DEF   = 100000000;
  localparam int unsigned DIV_W_DEF         = 27;

endpackage

// File: rtl/elevator_tick_gen_rise_detect.sv
// rtl/elevator_tick_gen_rise_detect.sv - per-bit rising-edge detector for floor sensors
module rise_detect #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  // Combinational so a restart acts in the same cycle the sensor rises
  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/elevator_tick_gen.sv
// rtl/elevator_tick_gen.sv - mode-selectable tick/square-wave timebase with floor restart
module elevator_tick_gen
  import elevator_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = CLK_FREQ_HZ,
  parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int unsigned DOOR_CYCLES   = DOOR_CYCLES_DEF,
  parameter int unsigned DIV_W         = DIV_W_DEF,
  parameter int unsigned N_FLOORS      = 3,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                clk_50,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  input  logic [N_FLOORS-1:0] floor_hit,
  output logic                tick,
  output logic                sq,
  output logic [CNT_W-1:0]    tick_count,
  output logic                busy
);

  localparam longint unsigned LP_DIV_MAX = (64'd1 << DIV_W) - 64'd1;
  localparam logic [DIV_W-1:0] LP_TRAVEL = DIV_W'(TRAVEL_CYCLES);
  localparam logic [DIV_W-1:0] LP_DOOR   = DIV_W'(DOOR_CYCLES);

  if (CLK_FREQ == 0) begin : g_bad_clk
    $error("elevator_tick_gen: CLK_FREQ must be non-zero");
  end
  if (TRAVEL_CYCLES < 2 || DOOR_CYCLES < 2) begin : g_bad_period
    $error("elevator_tick_gen: TRAVEL_CYCLES and DOOR_CYCLES must be >= 2");
  end
  if (longint'(TRAVEL_CYCLES) > LP_DIV_MAX || longint'(DOOR_CYCLES) > LP_DIV_MAX) begin : g_bad_width
    $error("elevator_tick_gen: period does not fit in DIV_W bits");
  end

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_tick;
  logic                r_sq;
  logic [CNT_W-1:0]    r_tick_count;
  logic [N_FLOORS-1:0] w_rise;
  logic                w_restart;
  logic [DIV_W-1:0]    w_period;
  logic                w_terminal;

  rise_detect #(.W(N_FLOORS)) u_rise_detect (
    .i_clk  (clk_50),
    .i_rst  (rst),
    .i_d    (floor_hit),
    .o_rise (w_rise)
  );

  assign w_restart = |w_rise;
  assign w_period  = (mode == MODE_DOOR) ? LP_DOOR : LP_TRAVEL;
  // >= rather than == so a mid-period switch to a shorter period ticks instead of wrapping
  assign w_terminal = (r_div_cnt >= (w_period - DIV_W'(1)));

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_div_cnt    <= '0;
      r_tick       <= 1'b0;
      r_sq         <= 1'b0;
      r_tick_count <= '0;
    end else if (w_restart) begin
      r_div_cnt    <= '0;
      r_tick       <= 1'b0;
      r_sq         <= 1'b0;
      r_tick_count <= '0;
    end else if (!enable) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (w_terminal) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
      r_sq      <= ~r_sq;
      if (r_tick_count != {CNT_W{1'b1}}) begin
        r_tick_count <= r_tick_count + CNT_W'(1);
      end
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_tick    <= 1'b0;
    end
  end

  assign tick       = r_tick;
  assign sq         = r_sq;
  assign tick_count = r_tick_count;
  assign busy       = enable & (r_div_cnt != '0);

endmodule
